prl_tx_sequencer: RTL and testbench
===================================

Name: prl_tx_sequencer

Overview:
Clocked controller for the USB-PD protocol-layer transmit path. It accepts a transmit request and sequences the message builder and the PHY. It then times the GoodCRC acknowledgement, matches its MessageID, retries on timeout and reports success or failure. It owns RetryCounter, the CRCReceiveTimer and the 3-bit MessageIDCounter; the message builder only concatenates header and data objects.

Parameters:
RETRY_MAX, 3, retries after the first attempt (total attempts = RETRY_MAX+1)
CRC_TIMEOUT, 6, CRCReceiveTimer reload value in clock cycles (>=1)
TIMER_W, 8, CRCReceiveTimer width; CRC_TIMEOUT < 2**TIMER_W

Ports:
CLK  in  1  clock, rising edge
RESET_L  in  1  asynchronous active-low reset
TX_REQ  in  1  transmit request, sampled only in IDLE
TRANSMIT  in  3  message type; 0-5 valid, 6-7 rejected
PHY_DONE  in  1  PHY finished sending the frame (1-cycle pulse)
GOODCRC_VALID  in  1  GoodCRC received (1-cycle pulse)
GOODCRC_MSGID  in  3  MessageID carried in the GoodCRC
MSGID_RESET  in  1  soft reset: clear MessageIDCounter
RX_MSG_ARRIVED  in  1  incoming message detected (used only with PRL_TX_DISCARD_EN)
TX_TYPE  out  3  latched TRANSMIT value, held from acceptance through report
BUILD_LOAD  out  1  1-cycle pulse: builder latches header/data objects
BUILD_MSGID  out  3  MessageID to insert in the header, valid with BUILD_LOAD
PHY_START  out  1  1-cycle pulse: PHY begins transmission
TX_BUSY  out  1  high in every state except IDLE
TX_SUCCESS  out  1  1-cycle pulse
TX_FAILED  out  1  1-cycle pulse
TX_REJECT  out  1  1-cycle pulse for TRANSMIT 6/7
TX_DISCARDED  out  1  1-cycle pulse (feature only; otherwise tied 0)

Behaviour:
- Reset (RESET_L=0, asynchronous): state IDLE; all outputs 0; msg_id=0, retry_cnt=0, timer=0.
- Reset asserted mid-operation aborts immediately; no report pulse is produced.
- States (4-bit encoding): IDLE, RESET_RETRY, CONSTRUCT, SEND, WAIT_PHY, WAIT_CRC, CHECK_RETRY, REPORT_SUCCESS, REPORT_FAILURE.
- IDLE:
  - TX_REQ=1 and TRANSMIT<=5: latch TX_TYPE, go to RESET_RETRY.
  - TX_REQ=1 and TRANSMIT>=6: TX_REJECT=1 for 1 cycle, stay in IDLE.
- RESET_RETRY: retry_cnt<=0; go to CONSTRUCT.
- CONSTRUCT: BUILD_LOAD=1, BUILD_MSGID=msg_id; go to SEND.
- SEND: PHY_START=1; go to WAIT_PHY.
- WAIT_PHY: hold until PHY_DONE. On PHY_DONE: timer<=CRC_TIMEOUT, go to WAIT_CRC. No timeout in this state.
- WAIT_CRC (timer decrements by 1 every cycle in this state):
  - GOODCRC_VALID with GOODCRC_MSGID==msg_id: go to REPORT_SUCCESS.
  - GoodCRC with a mismatched ID: ignored; timer keeps running.
  - Timer==1 with no matching GoodCRC: go to CHECK_RETRY (exactly CRC_TIMEOUT cycles in WAIT_CRC).
  - Matching GoodCRC in the same cycle the timer expires: success wins.
- CHECK_RETRY:
  - retry_cnt<RETRY_MAX: retry_cnt++, go to CONSTRUCT; the same msg_id is resent.
  - Otherwise: go to REPORT_FAILURE.
- REPORT_SUCCESS / REPORT_FAILURE: TX_SUCCESS / TX_FAILED=1 for 1 cycle; msg_id<=msg_id+1 mod 8 (7 wraps to 0); go to IDLE.
- Latency: TX_REQ sampled at edge N → BUILD_LOAD in cycle N+2 → PHY_START in cycle N+3.
- TX_REQ while TX_BUSY=1: ignored and not queued.
- MSGID_RESET: msg_id<=0 in any state, with priority over a report increment in the same cycle; the current transfer continues.

Optional Feature:
PRL_TX_DISCARD_EN
- Defined: RX_MSG_ARRIVED=1 in CONSTRUCT, SEND, WAIT_PHY or WAIT_CRC aborts the transfer.
  - TX_DISCARDED=1 for 1 cycle, then IDLE; msg_id is not incremented.
  - If it coincides with a matching GoodCRC, success wins.
- Undefined: RX_MSG_ARRIVED is ignored and TX_DISCARDED is tied 0.

Decomposition:
- Package prl_pkg:
  - state enum (4-bit)
  - TRANSMIT encodings TX_SOP=0 … TX_MAX_VALID=5
  - MSGID_W=3
  - defaults for RETRY_MAX and CRC_TIMEOUT
- Sub-module prl_crc_timer: loadable down-counter (load, value, en → expired).

Test Plan:
- TRANSMIT=0, TX_REQ pulse, then PHY_DONE, then GOODCRC_VALID with MSGID=0 on the 3rd WAIT_CRC cycle → BUILD_LOAD at N+2, PHY_START at N+3, TX_SUCCESS once, next BUILD_MSGID=1.
- Never send GoodCRC, RETRY_MAX=3 → 4 PHY_START pulses, each WAIT_CRC lasts 6 cycles, then TX_FAILED once, msg_id advances by 1.
- GoodCRC with MSGID=5 while msg_id=2, then no valid GoodCRC → mismatch ignored, retry occurs, BUILD_MSGID=2 again.
- Eight successful transfers → BUILD_MSGID sequence 0..7 then 0; MSGID_RESET mid-transfer → next report leaves msg_id=0.
- TRANSMIT=6 with TX_REQ → TX_REJECT pulse, TX_BUSY stays 0; RESET_L low during WAIT_CRC → all outputs 0, IDLE, no report pulse.
- With PRL_TX_DISCARD_EN: RX_MSG_ARRIVED in WAIT_PHY → TX_DISCARDED, msg_id unchanged; the same cycle as a matching GoodCRC → TX_SUCCESS only.

Source files
------------

// File: rtl/prl_tx_sequencer_pkg.sv
// rtl/prl_tx_sequencer_pkg.sv - shared types and constants for the PD protocol-layer transmit sequencer
package prl_pkg;

  localparam int MSGID_W         = 3;
  localparam int RETRY_MAX_DEF   = 3;
  localparam int CRC_TIMEOUT_DEF = 6;

  localparam logic [2:0] TX_SOP        = 3'd0;
  localparam logic [2:0] TX_SOP_P      = 3'd1;
  localparam logic [2:0] TX_SOP_PP     = 3'd2;
  localparam logic [2:0] TX_SOP_DBG_P  = 3'd3;
  localparam logic [2:0] TX_SOP_DBG_PP = 3'd4;
  localparam logic [2:0] TX_MAX_VALID  = 3'd5;

  typedef enum logic [3:0] {
    ST_IDLE           = 4'd0,
    ST_RESET_RETRY    = 4'd1,
    ST_CONSTRUCT      = 4'd2,
    ST_SEND           = 4'd3,
    ST_WAIT_PHY       = 4'd4,
    ST_WAIT_CRC       = 4'd5,
    ST_CHECK_RETRY    = 4'd6,
    ST_REPORT_SUCCESS = 4'd7,
    ST_REPORT_FAILURE = 4'd8
  } prl_state_e;

endpackage

// File: rtl/prl_tx_sequencer_if.sv
// rtl/prl_tx_sequencer_if.sv - request, builder, PHY and GoodCRC signals of the transmit sequencer
interface prl_tx_sequencer_if;
  import prl_pkg::*;

  logic               TX_REQ;
  logic [2:0]         TRANSMIT;
  logic               PHY_DONE;
  logic               GOODCRC_VALID;
  logic [MSGID_W-1:0] GOODCRC_MSGID;
  logic               MSGID_RESET;
  logic               RX_MSG_ARRIVED;
  logic [2:0]         TX_TYPE;
  logic               BUILD_LOAD;
  logic [MSGID_W-1:0] BUILD_MSGID;
  logic               PHY_START;
  logic               TX_BUSY;
  logic               TX_SUCCESS;
  logic               TX_FAILED;
  logic               TX_REJECT;
  logic               TX_DISCARDED;

  modport master (
    output TX_REQ, TRANSMIT, PHY_DONE, GOODCRC_VALID, GOODCRC_MSGID, MSGID_RESET, RX_MSG_ARRIVED,
    input  TX_TYPE, BUILD_LOAD, BUILD_MSGID, PHY_START, TX_BUSY, TX_SUCCESS, TX_FAILED,
           TX_REJECT, TX_DISCARDED
  );

  modport slave (
    input  TX_REQ, TRANSMIT, PHY_DONE, GOODCRC_VALID, GOODCRC_MSGID, MSGID_RESET, RX_MSG_ARRIVED,
    output TX_TYPE, BUILD_LOAD, BUILD_MSGID, PHY_START, TX_BUSY, TX_SUCCESS, TX_FAILED,
           TX_REJECT, TX_DISCARDED
  );

endinterface

// File: rtl/prl_tx_sequencer_crc_timer.sv
// rtl/prl_tx_sequencer_crc_timer.sv - loadable down-counter used as CRCReceiveTimer
module prl_crc_timer #(
  parameter int TIMER_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] value,
  input  logic               en,
  output logic               expired
);

  logic [TIMER_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= value;
    end else if (en && r_count != '0) begin
      r_count <= r_count - TIMER_W'(1);
    end
  end

  // Expiry is flagged in the last counting cycle so the owner spends exactly 'value' cycles waiting
  assign expired = (r_count == TIMER_W'(1));

endmodule

// File: rtl/prl_tx_sequencer.sv
// rtl/prl_tx_sequencer.sv - PD transmit sequencer: build, send, GoodCRC wait, retry, report (option: PRL_TX_DISCARD_EN)
module prl_tx_sequencer
  import prl_pkg::*;
#(
  parameter int RETRY_MAX   = RETRY_MAX_DEF,
  parameter int CRC_TIMEOUT = CRC_TIMEOUT_DEF,
  parameter int TIMER_W     = 8
) (
  input logic               CLK,
  input logic               RESET_L,
  prl_tx_sequencer_if.slave bus
);

  localparam int RC_W = $clog2(RETRY_MAX + 2);

  prl_state_e         r_state;
  logic [MSGID_W-1:0] r_msg_id;
  logic [RC_W-1:0]    r_retry_cnt;
  logic [2:0]         r_tx_type;
  logic               r_build_load;
  logic [MSGID_W-1:0] r_build_msgid;
  logic               r_phy_start;
  logic               r_busy;
  logic               r_tx_success;
  logic               r_tx_failed;
  logic               r_tx_reject;
  logic               r_tx_discarded;

  logic w_discard;
  logic w_match;
  logic w_timer_load;
  logic w_timer_en;
  logic w_timer_expired;

`ifdef PRL_TX_DISCARD_EN
  assign w_discard = bus.RX_MSG_ARRIVED;
`else
  assign w_discard = 1'b0;
`endif

  assign w_match      = bus.GOODCRC_VALID && (bus.GOODCRC_MSGID == r_msg_id);
  assign w_timer_load = (r_state == ST_WAIT_PHY) && bus.PHY_DONE;
  assign w_timer_en   = (r_state == ST_WAIT_CRC);

  prl_crc_timer #(.TIMER_W(TIMER_W)) u_crc_timer (
    .clk     (CLK),
    .rst_n   (RESET_L),
    .load    (w_timer_load),
    .value   (TIMER_W'(CRC_TIMEOUT)),
    .en      (w_timer_en),
    .expired (w_timer_expired)
  );

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      r_state        <= ST_IDLE;
      r_msg_id       <= '0;
      r_retry_cnt    <= '0;
      r_tx_type      <= '0;
      r_build_load   <= 1'b0;
      r_build_msgid  <= '0;
      r_phy_start    <= 1'b0;
      r_busy         <= 1'b0;
      r_tx_success   <= 1'b0;
      r_tx_failed    <= 1'b0;
      r_tx_reject    <= 1'b0;
      r_tx_discarded <= 1'b0;
    end else begin
      r_build_load   <= 1'b0;
      r_build_msgid  <= '0;
      r_phy_start    <= 1'b0;
      r_tx_success   <= 1'b0;
      r_tx_failed    <= 1'b0;
      r_tx_reject    <= 1'b0;
      r_tx_discarded <= 1'b0;

      // Outputs are registered with the transition so each one is high exactly while in its state
      case (r_state)
        ST_IDLE: begin
          if (bus.TX_REQ) begin
            if (bus.TRANSMIT <= TX_MAX_VALID) begin
              r_tx_type <= bus.TRANSMIT;
              r_busy    <= 1'b1;
              r_state   <= ST_RESET_RETRY;
            end else begin
              r_tx_reject <= 1'b1;
            end
          end
        end
        ST_RESET_RETRY: begin
          r_retry_cnt   <= '0;
          r_build_load  <= 1'b1;
          r_build_msgid <= bus.MSGID_RESET ? '0 : r_msg_id;
          r_state       <= ST_CONSTRUCT;
        end
        ST_CONSTRUCT, ST_SEND, ST_WAIT_PHY: begin
          if (w_discard) begin
            r_tx_discarded <= 1'b1;
            r_busy         <= 1'b0;
            r_state        <= ST_IDLE;
          end else if (r_state == ST_CONSTRUCT) begin
            r_phy_start <= 1'b1;
            r_state     <= ST_SEND;
          end else if (r_state == ST_SEND) begin
            r_state <= ST_WAIT_PHY;
          end else if (bus.PHY_DONE) begin
            r_state <= ST_WAIT_CRC;
          end
        end
        ST_WAIT_CRC: begin
          if (w_match) begin
            r_tx_success <= 1'b1;
            r_state      <= ST_REPORT_SUCCESS;
          end else if (w_discard) begin
            r_tx_discarded <= 1'b1;
            r_busy         <= 1'b0;
            r_state        <= ST_IDLE;
          end else if (w_timer_expired) begin
            r_state <= ST_CHECK_RETRY;
          end
        end
        ST_CHECK_RETRY: begin
          if (r_retry_cnt < RC_W'(RETRY_MAX)) begin
            r_retry_cnt   <= r_retry_cnt + RC_W'(1);
            r_build_load  <= 1'b1;
            r_build_msgid <= bus.MSGID_RESET ? '0 : r_msg_id;
            r_state       <= ST_CONSTRUCT;
          end else begin
            r_tx_failed <= 1'b1;
            r_state     <= ST_REPORT_FAILURE;
          end
        end
        ST_REPORT_SUCCESS, ST_REPORT_FAILURE: begin
          r_msg_id <= r_msg_id + MSGID_W'(1);
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase

      // Soft reset of the MessageID overrides a same-cycle report increment
      if (bus.MSGID_RESET) begin
        r_msg_id <= '0;
      end
    end
  end

  assign bus.TX_TYPE      = r_tx_type;
  assign bus.BUILD_LOAD   = r_build_load;
  assign bus.BUILD_MSGID  = r_build_msgid;
  assign bus.PHY_START    = r_phy_start;
  assign bus.TX_BUSY      = r_busy;
  assign bus.TX_SUCCESS   = r_tx_success;
  assign bus.TX_FAILED    = r_tx_failed;
  assign bus.TX_REJECT    = r_tx_reject;
  assign bus.TX_DISCARDED = r_tx_discarded;

endmodule

// File: tb/tb_prl_tx_sequencer.sv
// tb/tb_prl_tx_sequencer.sv - scoreboard bench for prl_tx_sequencer (discard cases under PRL_TX_DISCARD_EN)
module tb_prl_tx_sequencer;
  import prl_pkg::*;

  localparam int RMAX = 3;
  localparam int CTO  = 6;
  localparam logic [3:0] SUCC = 4'b0001;
  localparam logic [3:0] FAILD = 4'b0010;
  localparam logic [3:0] REJ  = 4'b0100;
  localparam logic [3:0] DISC = 4'b1000;

  logic CLK = 1'b0;
  logic RESET_L = 1'b0;

  prl_tx_sequencer_if bus();

  prl_tx_sequencer #(.RETRY_MAX(RMAX), .CRC_TIMEOUT(CTO), .TIMER_W(8)) dut (
    .CLK     (CLK),
    .RESET_L (RESET_L),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail = 0;
  int n_phy_start = 0;
  logic [2:0] m_msgid = 3'd0;
  logic [2:0] q_msgid[$];
  logic [3:0] q_rep[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {19'd0, bus.TX_TYPE, bus.BUILD_LOAD, bus.BUILD_MSGID, bus.PHY_START, bus.TX_BUSY,
            bus.TX_SUCCESS, bus.TX_FAILED, bus.TX_REJECT, bus.TX_DISCARDED};
  endfunction

  function automatic logic sig(input int sel);
    case (sel)
      0:       return bus.PHY_START;
      1:       return bus.TX_FAILED;
      default: return bus.TX_SUCCESS;
    endcase
  endfunction

  // Scoreboard: every builder load and every report pulse must match the next queued expectation
  always @(negedge CLK) begin
    logic [3:0] code;
    logic [3:0] er;
    if (RESET_L) begin
      if (bus.PHY_START) n_phy_start++;
      if (bus.BUILD_LOAD) begin
        chk("build_expected", 32'(q_msgid.size() > 0), 1);
        if (q_msgid.size() > 0) chk("build_msgid", bus.BUILD_MSGID, q_msgid.pop_front());
      end
      code = {bus.TX_DISCARDED, bus.TX_REJECT, bus.TX_FAILED, bus.TX_SUCCESS};
      if (code != 4'd0) begin
        er = 4'd0;
        if (q_rep.size() > 0) er = q_rep.pop_front();
        chk("report", code, er);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_req(input logic [2:0] t);
    bus.TX_REQ = 1'b1;
    bus.TRANSMIT = t;
    tick();
    bus.TX_REQ = 1'b0;
  endtask

  task automatic wait_sig(input string tag, input int sel, input int budget, output int cyc);
    cyc = 0;
    while (!sig(sel) && cyc < budget) begin
      tick();
      cyc++;
    end
    chk({tag, "_seen"}, sig(sel), 1);
  endtask

  task automatic pulse_phy_done();
    bus.PHY_DONE = 1'b1;
    tick();
    bus.PHY_DONE = 1'b0;
  endtask

  task automatic goodcrc(input logic [2:0] id);
    bus.GOODCRC_VALID = 1'b1;
    bus.GOODCRC_MSGID = id;
    tick();
    bus.GOODCRC_VALID = 1'b0;
  endtask

  task automatic xfer_ok(input logic [2:0] t);
    int c;
    q_msgid.push_back(m_msgid);
    q_rep.push_back(SUCC);
    send_req(t);
    wait_sig("xfer_phy", 0, 20, c);
    tick();
    pulse_phy_done();
    goodcrc(m_msgid);
    chk("xfer_success", bus.TX_SUCCESS, 1);
    tick();
    m_msgid = m_msgid + 3'd1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    bus.TX_REQ = 0; bus.TRANSMIT = 0; bus.PHY_DONE = 0; bus.GOODCRC_VALID = 0;
    bus.GOODCRC_MSGID = 0; bus.MSGID_RESET = 0; bus.RX_MSG_ARRIVED = 0;
    tick(3);
    chk("reset_outs", all_outs(), 0);
    RESET_L = 1'b1;
    tick();

    // Basic success with latency checks
    q_msgid.push_back(m_msgid);
    q_rep.push_back(SUCC);
    send_req(TX_SOP);
    chk("lat_n1_build", bus.BUILD_LOAD, 0);
    chk("busy_on", bus.TX_BUSY, 1);
    tick();
    chk("lat_n2_build", bus.BUILD_LOAD, 1);
    tick();
    chk("lat_n3_phy", bus.PHY_START, 1);
    tick();
    pulse_phy_done();
    tick(2);
    goodcrc(m_msgid);
    chk("t1_success", bus.TX_SUCCESS, 1);
    chk("t1_type", bus.TX_TYPE, TX_SOP);
    tick();
    chk("busy_off", bus.TX_BUSY, 0);
    m_msgid = m_msgid + 3'd1;

    // No GoodCRC at all: RETRY_MAX retries then failure
    n_phy_start = 0;
    repeat (RMAX + 1) q_msgid.push_back(m_msgid);
    q_rep.push_back(FAILD);
    send_req(TX_SOP_PP);
    chk("fail_type", bus.TX_TYPE, TX_SOP_PP);
    for (int a = 0; a <= RMAX; a++) begin
      wait_sig("attempt_phy", 0, 20, c);
      tick();
      pulse_phy_done();
      if (a < RMAX) begin
        wait_sig("retry_phy", 0, 40, c);
        chk("retry_gap", c, CTO + 2);
      end else begin
        wait_sig("fail", 1, 40, c);
        chk("fail_gap", c, CTO + 1);
      end
    end
    chk("phy_start_count", n_phy_start, RMAX + 1);
    chk("busy_in_report", bus.TX_BUSY, 1);
    tick();
    m_msgid = m_msgid + 3'd1;

    // Mismatched GoodCRC ignored; request while busy ignored
    q_msgid.push_back(m_msgid);
    q_msgid.push_back(m_msgid);
    q_rep.push_back(SUCC);
    send_req(TX_SOP_P);
    wait_sig("mm_phy", 0, 20, c);
    tick();
    bus.TX_REQ = 1'b1;
    bus.TRANSMIT = TX_SOP_DBG_P;
    tick();
    bus.TX_REQ = 1'b0;
    chk("busy_req_type", bus.TX_TYPE, TX_SOP_P);
    pulse_phy_done();
    tick();
    goodcrc(3'd5);
    wait_sig("mm_retry", 0, 40, c);
    chk("mm_retry_gap", c, CTO);
    tick();
    pulse_phy_done();
    goodcrc(m_msgid);
    chk("mm_success", bus.TX_SUCCESS, 1);
    tick();
    m_msgid = m_msgid + 3'd1;

    // MessageID wrap: 0..7 then 0
    bus.MSGID_RESET = 1'b1;
    tick();
    bus.MSGID_RESET = 1'b0;
    m_msgid = 3'd0;
    for (int i = 0; i < 9; i++) xfer_ok(3'(i % 6));

    // MSGID_RESET in the report cycle beats the increment
    q_msgid.push_back(m_msgid);
    q_rep.push_back(SUCC);
    send_req(TX_SOP);
    wait_sig("mr_phy", 0, 20, c);
    tick();
    pulse_phy_done();
    goodcrc(m_msgid);
    bus.MSGID_RESET = 1'b1;
    tick();
    bus.MSGID_RESET = 1'b0;
    m_msgid = 3'd0;
    xfer_ok(TX_SOP);

    // Reserved TRANSMIT values are rejected
    q_rep.push_back(REJ);
    send_req(3'd6);
    chk("reject6", bus.TX_REJECT, 1);
    chk("reject6_busy", bus.TX_BUSY, 0);
    tick();
    chk("reject_one_cycle", bus.TX_REJECT, 0);
    q_rep.push_back(REJ);
    send_req(3'd7);
    chk("reject7", bus.TX_REJECT, 1);
    chk("reject7_busy", bus.TX_BUSY, 0);
    tick();

    // Asynchronous reset during WAIT_CRC
    q_msgid.push_back(m_msgid);
    send_req(TX_SOP_DBG_PP);
    wait_sig("rst_phy", 0, 20, c);
    tick();
    pulse_phy_done();
    tick();
    #1 RESET_L = 1'b0;
    #1 chk("async_reset_outs", all_outs(), 0);
    tick(2);
    RESET_L = 1'b1;
    tick(CTO + 4);
    chk("post_reset_idle", all_outs(), 0);
    m_msgid = 3'd0;
    xfer_ok(TX_SOP);

`ifdef PRL_TX_DISCARD_EN
    q_msgid.push_back(m_msgid);
    q_rep.push_back(DISC);
    send_req(TX_SOP);
    wait_sig("disc_phy", 0, 20, c);
    tick();
    bus.RX_MSG_ARRIVED = 1'b1;
    tick();
    bus.RX_MSG_ARRIVED = 1'b0;
    chk("discard_pulse", bus.TX_DISCARDED, 1);
    chk("discard_busy", bus.TX_BUSY, 0);
    tick();
    xfer_ok(TX_SOP);

    q_msgid.push_back(m_msgid);
    q_rep.push_back(SUCC);
    send_req(TX_SOP);
    wait_sig("disc2_phy", 0, 20, c);
    tick();
    pulse_phy_done();
    bus.RX_MSG_ARRIVED = 1'b1;
    goodcrc(m_msgid);
    bus.RX_MSG_ARRIVED = 1'b0;
    chk("disc_vs_success", {bus.TX_SUCCESS, bus.TX_DISCARDED}, 2'b10);
    tick();
    m_msgid = m_msgid + 3'd1;
`endif

    tick(3);
    chk("sb_msgid_drained", q_msgid.size(), 0);
    chk("sb_report_drained", q_rep.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
